// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: mode selectors,
// 2-bit counter encodings, BTB entry layout and saturating counter math.
package bp_pkg;

  localparam int unsigned MODE_BIMODAL = 0;
  localparam int unsigned MODE_GSHARE  = 1;

  localparam int unsigned BP_ADDR_W = 32;
  localparam int unsigned BP_TAG_W  = 8;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
    logic                 is_cond;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Table of 2-bit saturating direction counters: one combinational read port,
// one registered update port, synchronous active-low reset to weakly not-taken.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned N = 1 << IDX_W;

  logic [1:0] ctr_q [N];
  logic [1:0] ctr_d [N];

  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) begin
      ctr_d[upd_idx] = upd_taken ? sat_inc(ctr_q[upd_idx]) : sat_dec(ctr_q[upd_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        ctr_q[i] <= WNT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// IF-stage branch predictor: BTB plus 2-bit counter table (bimodal or gshare),
// trained from ID-stage resolution; drives next-PC selection and IF/ID flush.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W = BP_ADDR_W,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = BP_TAG_W,
  parameter int unsigned MODE   = MODE_BIMODAL,
  parameter int unsigned GHR_W  = 4,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_is_cond,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic [GHR_W-1:0]  upd_ghr,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned BTB_N = 1 << IDX_W;

  function automatic logic [IDX_W-1:0] bidx_f(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_f(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+TAG_W+1:IDX_W+2];
  endfunction

  function automatic logic [IDX_W-1:0] cidx_f(input logic [ADDR_W-1:0] pc,
                                              input logic [GHR_W-1:0]  ghr);
    if (MODE == MODE_GSHARE) begin
      return bidx_f(pc) ^ IDX_W'(ghr);
    end
    return bidx_f(pc);
  endfunction

  btb_entry_t        btb_q [BTB_N];
  btb_entry_t        btb_d [BTB_N];
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [PERF_W-1:0] perf_lookups_q, perf_lookups_d;
  logic [PERF_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

  btb_entry_t        lk_entry;
  logic              lk_hit;
  logic [1:0]        lk_ctr;
  logic [IDX_W-1:0]  lk_cidx;
  logic [IDX_W-1:0]  upd_cidx;
  logic [IDX_W-1:0]  upd_bidx;
  logic              upd_hit;

  // Lookup path: reads pre-update contents, no bypass from the update port.
  assign lk_entry    = btb_q[bidx_f(if_pc)];
  assign lk_hit      = lk_entry.valid && (TAG_W'(lk_entry.tag) == tag_f(if_pc));
  assign lk_cidx     = cidx_f(if_pc, ghr_q);
  assign pred_hit    = lk_hit;
  assign pred_taken  = lk_hit && (!lk_entry.is_cond || (lk_ctr >= 2'(WT)));
  assign pred_target = pred_taken ? ADDR_W'(lk_entry.target) : if_pc + ADDR_W'(4);
  assign pred_ghr    = ghr_q;

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);

  assign upd_cidx = cidx_f(upd_pc, upd_ghr);
  assign upd_bidx = bidx_f(upd_pc);
  assign upd_hit  = btb_q[upd_bidx].valid && (TAG_W'(btb_q[upd_bidx].tag) == tag_f(upd_pc));

  bp_sat_counter_table #(
    .IDX_W (IDX_W)
  ) u_ctr_table (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (lk_cidx),
    .rd_ctr    (lk_ctr),
    .upd_en    (upd_valid && upd_is_cond),
    .upd_idx   (upd_cidx),
    .upd_taken (upd_taken)
  );

  // BTB training: refresh target on a taken hit, allocate on a taken miss.
  always_comb begin
    btb_d = btb_q;
    if (upd_valid && upd_taken) begin
      if (upd_hit) begin
        btb_d[upd_bidx].target = BP_ADDR_W'(upd_target);
      end else begin
        btb_d[upd_bidx].valid   = 1'b1;
        btb_d[upd_bidx].tag     = BP_TAG_W'(tag_f(upd_pc));
        btb_d[upd_bidx].target  = BP_ADDR_W'(upd_target);
        btb_d[upd_bidx].is_cond = upd_is_cond;
      end
    end
  end

  // Global history: mispredict recovery wins over fetch-time speculation.
  always_comb begin
    ghr_d = ghr_q;
    if (MODE == MODE_GSHARE) begin
      if (mispredict) begin
        ghr_d = upd_is_cond ? {upd_ghr[GHR_W-2:0], upd_taken} : upd_ghr;
      end else if (if_valid && lk_hit && lk_entry.is_cond) begin
        ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
      end
    end else begin
      ghr_d = '0;
    end
  end

  always_comb begin
    perf_lookups_d     = perf_lookups_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (if_valid && (perf_lookups_q != '1)) begin
      perf_lookups_d = perf_lookups_q + PERF_W'(1);
    end
    if (mispredict && (perf_mispredicts_q != '1)) begin
      perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(BTB_N); i++) begin
        btb_q[i] <= '0;
      end
      ghr_q              <= '0;
      perf_lookups_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      btb_q              <= btb_d;
      ghr_q              <= ghr_d;
      perf_lookups_q     <= perf_lookups_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_lookups     = perf_lookups_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: a bimodal and a gshare instance share stimulus; a
// behavioural model predicts every lookup/update cycle and a monitor compares.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic [3:0]  upd_ghr;

  logic        hit0, taken0, mis0, hit1, taken1, mis1;
  logic [31:0] tgt0, rpc0, tgt1, rpc1;
  logic [3:0]  ghr0, ghr1;
  logic [15:0] pl0, pm0;
  logic [3:0]  pl1, pm1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(.MODE(0), .PERF_W(16)) dut0 (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .pred_hit(hit0), .pred_taken(taken0), .pred_target(tgt0), .pred_ghr(ghr0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(mis0), .redirect_pc(rpc0), .perf_lookups(pl0), .perf_mispredicts(pm0)
  );

  branch_target_predictor #(.MODE(1), .PERF_W(4)) dut1 (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .pred_hit(hit1), .pred_taken(taken1), .pred_target(tgt1), .pred_ghr(ghr1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(mis1), .redirect_pc(rpc1), .perf_lookups(pl1), .perf_mispredicts(pm1)
  );

  // Reference model: plain arrays per instance (0 = bimodal, 1 = gshare).
  bit          mv   [2][16];
  int          mtag [2][16];
  logic [31:0] mtgt [2][16];
  bit          mic  [2][16];
  int          mctr [2][16];
  int          mghr [2];
  int          mpl  [2];
  int          mpm  [2];
  int          pmax [2] = '{65535, 15};

  typedef struct {
    bit          hit;
    bit          taken;
    logic [31:0] tgt;
    int          ghr;
    bit          upd;
    bit          mis;
    logic [31:0] rpc;
    int          pl;
    int          pm;
  } exp_t;

  exp_t sb [2][$];

  task automatic chk(input string name, input int m, input longint unsigned act,
                     input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, m, act, exp, $time);
    end
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic int tagof(input logic [31:0] pc);
    return int'((pc >> 6) % 32'd256);
  endfunction

  function automatic int cidx(input int m, input logic [31:0] pc, input int g);
    return (m == 1) ? (bidx(pc) ^ g) : bidx(pc);
  endfunction

  function automatic bit model_mis();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
  endfunction

  task automatic look(input int m, input logic [31:0] pc, output bit h, output bit t,
                      output logic [31:0] tg);
    int b;
    b  = bidx(pc);
    h  = mv[m][b] && (mtag[m][b] == tagof(pc));
    t  = h && (!mic[m][b] || (mctr[m][cidx(m, pc, mghr[m])] >= 2));
    tg = t ? mtgt[m][b] : pc + 32'd4;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        mv[m][i]   = 1'b0;
        mctr[m][i] = 1;
      end
      mghr[m] = 0;
      mpl[m]  = 0;
      mpm[m]  = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit h, t, lic, mis, uh;
    logic [31:0] tg;
    int b, ci;
    if (!reset) begin
      model_reset();
      return;
    end
    mis = model_mis();
    for (int m = 0; m < 2; m++) begin
      look(m, if_pc, h, t, tg);
      lic = mic[m][bidx(if_pc)];
      if (upd_valid) begin
        if (upd_is_cond) begin
          ci = cidx(m, upd_pc, int'(upd_ghr));
          if (upd_taken) begin
            if (mctr[m][ci] < 3) mctr[m][ci]++;
          end else begin
            if (mctr[m][ci] > 0) mctr[m][ci]--;
          end
        end
        b  = bidx(upd_pc);
        uh = mv[m][b] && (mtag[m][b] == tagof(upd_pc));
        if (upd_taken) begin
          mtgt[m][b] = upd_target;
          if (!uh) begin
            mv[m][b]   = 1'b1;
            mtag[m][b] = tagof(upd_pc);
            mic[m][b]  = upd_is_cond;
          end
        end
      end
      if (m == 1) begin
        if (mis) begin
          mghr[m] = upd_is_cond ? (((int'(upd_ghr) << 1) | int'(upd_taken)) % 16)
                                : int'(upd_ghr);
        end else if (if_valid && h && lic) begin
          mghr[m] = ((mghr[m] << 1) | int'(t)) % 16;
        end
      end
      if (if_valid && (mpl[m] < pmax[m])) mpl[m]++;
      if (mis && (mpm[m] < pmax[m])) mpm[m]++;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    if (!(if_valid || upd_valid)) return;
    for (int m = 0; m < 2; m++) begin
      look(m, if_pc, e.hit, e.taken, e.tgt);
      e.ghr = mghr[m];
      e.upd = upd_valid;
      e.mis = model_mis();
      e.rpc = upd_taken ? upd_target : upd_pc + 32'd4;
      e.pl  = mpl[m];
      e.pm  = mpm[m];
      sb[m].push_back(e);
    end
  endtask

  // Monitor: whenever a lookup or update is presented, pop and compare.
  always @(negedge clk) begin
    exp_t e;
    bit a_hit, a_taken, a_mis;
    logic [31:0] a_tgt, a_rpc;
    int a_ghr, a_pl, a_pm;
    if (if_valid || upd_valid) begin
      for (int m = 0; m < 2; m++) begin
        if (m == 0) begin
          a_hit = hit0; a_taken = taken0; a_tgt = tgt0; a_ghr = int'(ghr0);
          a_mis = mis0; a_rpc = rpc0; a_pl = int'(pl0); a_pm = int'(pm0);
        end else begin
          a_hit = hit1; a_taken = taken1; a_tgt = tgt1; a_ghr = int'(ghr1);
          a_mis = mis1; a_rpc = rpc1; a_pl = int'(pl1); a_pm = int'(pm1);
        end
        if (sb[m].size() == 0) begin
          chk("sb_underflow", m, 1, 0);
        end else begin
          e = sb[m].pop_front();
          chk("pred_hit", m, a_hit, e.hit);
          chk("pred_taken", m, a_taken, e.taken);
          chk("pred_target", m, a_tgt, e.tgt);
          chk("pred_ghr", m, a_ghr, e.ghr);
          chk("mispredict", m, a_mis, e.mis);
          if (e.upd) chk("redirect_pc", m, a_rpc, e.rpc);
          chk("perf_lookups", m, a_pl, e.pl);
          chk("perf_mispredicts", m, a_pm, e.pm);
        end
      end
    end
  end

  task automatic cyc(input bit rst, input bit iv, input logic [31:0] pc, input bit uv,
                     input logic [31:0] upc, input bit uc, input bit ut,
                     input logic [31:0] utg, input bit upt, input logic [31:0] uptg,
                     input logic [3:0] ug);
    @(posedge clk);
    model_step();
    #1;
    reset = rst; if_valid = iv; if_pc = pc; upd_valid = uv; upd_pc = upc;
    upd_is_cond = uc; upd_taken = ut; upd_target = utg; upd_pred_taken = upt;
    upd_pred_target = uptg; upd_ghr = ug;
    push_expected();
    #3;
  endtask

  task automatic lk(input logic [31:0] pc);
    cyc(1, 1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic up(input logic [31:0] pc, input bit c, input bit t, input logic [31:0] tg,
                    input bit pt, input logic [31:0] ptg, input logic [3:0] g);
    cyc(1, 0, 0, 1, pc, c, t, tg, pt, ptg, g);
  endtask

  task automatic idle(input bit rst);
    cyc(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    bit uv, iv, rst;
    logic [31:0] utg;
    reset = 1'b0; if_valid = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
    upd_pred_target = '0; upd_ghr = '0;
    model_reset();

    // Reset state and lookup counting
    idle(0);
    cyc(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_hit", 0, hit0, 0);
    chk("reset_target", 0, tgt0, 32'h44);
    chk("reset_perf", 0, pl0, 0);
    chk("reset_ghr", 1, ghr1, 0);
    lk(32'h40); lk(32'h40); lk(32'h40);
    idle(1);
    chk("three_lookups", 0, pl0, 3);

    // First taken update allocates and mispredicts
    up(32'h40, 1, 1, 32'h80, 0, 32'h44, 0);
    chk("alloc_mispredict", 0, mis0, 1);
    chk("alloc_redirect", 0, rpc0, 32'h80);
    lk(32'h40);
    chk("alloc_hit", 0, hit0, 1);
    chk("alloc_taken", 0, taken0, 1);
    chk("alloc_target", 0, tgt0, 32'h80);

    // Hysteresis
    repeat (3) up(32'h40, 1, 1, 32'h80, 1, 32'h80, 0);
    up(32'h40, 1, 0, 32'h80, 1, 32'h80, 0);
    lk(32'h40);
    chk("hyst_still_taken", 0, taken0, 1);
    up(32'h40, 1, 0, 32'h80, 1, 32'h80, 0);
    lk(32'h40);
    chk("hyst_not_taken", 0, taken0, 0);
    chk("hyst_target", 0, tgt0, 32'h44);

    // Alias replacement
    up(32'h40, 1, 1, 32'h80, 0, 32'h44, 0);
    lk(32'h440);
    chk("alias_miss", 0, hit0, 0);
    up(32'h440, 0, 1, 32'h100, 0, 32'h444, 0);
    lk(32'h40);
    chk("alias_evicted", 0, hit0, 0);
    lk(32'h440);
    chk("alias_jump_target", 0, tgt0, 32'h100);

    // Gshare speculation and recovery
    idle(0);
    up(32'h40, 1, 1, 32'h80, 1, 32'h80, 0);
    up(32'h40, 1, 1, 32'h80, 1, 32'h80, 0);
    up(32'h44, 1, 1, 32'h90, 1, 32'h90, 4'd1);
    lk(32'h40);
    chk("gs_taken_a", 1, taken1, 1);
    lk(32'h44);
    chk("gs_taken_b", 1, taken1, 1);
    idle(1);
    chk("gs_spec_ghr", 1, ghr1, 4'b0011);
    up(32'h80, 1, 0, 32'h0, 1, 32'h84, 4'b0001);
    chk("gs_mispredict", 1, mis1, 1);
    idle(1);
    chk("gs_recover_ghr", 1, ghr1, 4'b0010);

    // Same-cycle lookup/update and reset discarding an update
    idle(0);
    cyc(1, 1, 32'h40, 1, 32'h40, 1, 1, 32'h80, 0, 32'h44, 0);
    chk("same_cycle_miss", 0, hit0, 0);
    lk(32'h40);
    chk("next_cycle_hit", 0, hit0, 1);
    cyc(0, 1, 32'h40, 1, 32'h48, 1, 1, 32'hC0, 0, 32'h4C, 0);
    lk(32'h40);
    chk("reset_clears_btb", 0, hit0, 0);
    chk("reset_clears_perf", 0, pl0, 0);
    lk(32'h48);
    chk("reset_drops_alloc", 0, hit0, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      iv  = ($urandom_range(0, 3) != 0);
      uv  = $urandom_range(0, 1) != 0;
      utg = pick_pc();
      cyc(rst, iv, pick_pc(), uv, pick_pc(), 1'($urandom), 1'($urandom), utg,
          1'($urandom), ($urandom_range(0, 1) != 0) ? utg : pick_pc(), 4'($urandom));
    end
    idle(1);
    @(negedge clk);
    chk("sb_leftover0", 0, sb[0].size(), 0);
    chk("sb_leftover1", 1, sb[1].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined core.
- Replaces static "resolve in ID, flush IF/ID" behaviour with IF-stage prediction: a branch target buffer (BTB) plus a 2-bit saturating counter table.
- Counter indexing is selectable between bimodal and gshare.
- Looked up combinationally with the fetch PC; trained by the ID-stage branch resolution logic; drives next-PC selection and the IF/ID flush.

Parameters:
ADDR_W, 32, PC / target width
IDX_W, 4, log2 of BTB and counter-table entries (16)
TAG_W, 8, BTB tag width
MODE, 0, 0 = bimodal, 1 = gshare
GHR_W, 4, global history length; must be <= IDX_W
PERF_W, 16, performance counter width

Ports:
clk  in  1  clock
reset  in  1  reset; one clock; reset is synchronous and active-low
if_valid  in  1  fetch lookup active; low while the PC is stalled
if_pc  in  ADDR_W  fetch PC
pred_hit  out  1  BTB hit for if_pc
pred_taken  out  1  predicted taken
pred_target  out  ADDR_W  predicted next PC
pred_ghr  out  GHR_W  history snapshot used for this lookup; piped to ID
upd_valid  in  1  resolved control instruction in ID
upd_pc  in  ADDR_W  PC of the resolved instruction
upd_is_cond  in  1  1 = conditional branch, 0 = jump
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual taken target
upd_pred_taken  in  1  prediction made at fetch
upd_pred_target  in  ADDR_W  predicted next PC made at fetch
upd_ghr  in  GHR_W  pred_ghr snapshot carried with the instruction
mispredict  out  1  combinational; flush IF/ID and redirect
redirect_pc  out  ADDR_W  correct next PC when mispredict = 1
perf_lookups  out  PERF_W  count of valid lookups
perf_mispredicts  out  PERF_W  count of mispredicts

Behaviour:
- Field extraction:
  - bidx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - cidx = bidx (MODE 0), or bidx XOR zero-extended ghr (MODE 1)
- BTB entry: valid, tag, target, is_cond. Counter table: 2^IDX_W entries of 2 bits.
- Lookup (combinational, 0 latency):
  - pred_hit = valid & tag match
  - pred_taken = pred_hit & (!is_cond | ctr[1])
  - pred_target = pred_taken ? entry target : if_pc + 4
  - pred_ghr = current ghr
- Mispredict:
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target))
  - redirect_pc = upd_taken ? upd_target : upd_pc + 4
- Update (registered, effective the next cycle), when upd_valid:
  - Conditional: counter at cidx(upd_pc, upd_ghr) increments if taken (saturate at 3), else decrements (saturate at 0).
  - Entry at bidx(upd_pc):
    - BTB hit: target refreshed when taken.
    - BTB miss and taken: entry allocated or replaced (valid = 1, tag, target, is_cond); the counter is not reinitialised.
    - BTB miss and not taken: no allocation.
- GHR (MODE 1 only; held at 0 in MODE 0):
  - Priority 1: mispredict & upd_is_cond -> ghr <= {upd_ghr[GHR_W-2:0], upd_taken}.
  - Priority 1: mispredict & jump -> ghr <= upd_ghr.
  - Priority 2: else if if_valid & pred_hit & is_cond -> ghr <= {ghr[GHR_W-2:0], pred_taken} (speculative).
  - Otherwise hold.
- Simultaneous lookup and update of the same index: lookup sees pre-update contents. No bypass.
- Performance counters: perf_lookups increments on if_valid; perf_mispredicts increments on mispredict. Both saturate at all-ones and do not wrap.
- Reset (reset = 0 at a clk edge):
  - all BTB valid bits = 0
  - counters = 2'b01 (weakly not-taken)
  - ghr = 0
  - perf counters = 0
- Outputs after reset: pred_hit = 0, pred_taken = 0, pred_target = if_pc + 4, pred_ghr = 0.
- Reset mid-operation discards any pending update in the same cycle.
- upd_valid = 0 -> mispredict = 0; no state change apart from the GHR speculation and perf_lookups.
- Arithmetic: +4 and target compare are ADDR_W wide, wrapping modulo 2^ADDR_W.

Decomposition:
- Shared package bp_pkg:
  - MODE_BIMODAL / MODE_GSHARE constants
  - counter encodings SNT = 0, WNT = 1, WT = 2, ST = 3
  - btb_entry_t struct {valid, tag, target, is_cond}
  - sat_inc / sat_dec functions
- One natural sub-module, bp_sat_counter_table: 2^IDX_W x 2-bit array, one combinational read port, one registered update port, synchronous reset to WNT.
- BTB storage, GHR and perf counters stay in the top.

Test Plan:
1. Reset with if_pc = 0x40 -> pred_hit = 0, pred_target = 0x44; perf counters = 0; after 3 lookups perf_lookups = 3.
2. Update pc 0x40, cond, taken, target 0x80, upd_pred_taken = 0 -> mispredict = 1, redirect_pc = 0x80. Next cycle, lookup 0x40 -> hit, counter = 2, pred_taken = 1, pred_target = 0x80.
3. Hysteresis:
   - Drive 3 taken updates on 0x40 -> counter = 3.
   - One not-taken -> counter = 2, still predicts taken.
   - Second not-taken -> predicts not-taken, pred_target = 0x44.
4. Alias:
   - Allocate 0x40, then look up 0x440 (same bidx, different tag) -> pred_hit = 0.
   - Taken update on 0x440 replaces the entry; 0x40 then misses.
5. Gshare (MODE = 1):
   - Speculative history: two predicted-taken cond hits -> ghr = 0b0011.
   - Recovery: mispredict with upd_ghr = 0b0001, upd_taken = 0 -> ghr = 0b0010 next cycle.
6. Same-cycle conflict: lookup and allocating update on 0x40 together -> lookup misses that cycle, hits the next cycle. Lookup and update of 0x40 with reset = 0 -> all state cleared, no allocation.
